gpio_port: RTL

// - Memory-mapped GPIO port, direct downstream consumer of the decoder's gpio_mem_* interface.
// - Provides ATmega-style DDR/PORT/PIN registers, set/clear/toggle writes and pin-change interrupt flags.
// - Synchronises asynchronous pad inputs and drives pad output and output-enable.
// - Produces a single-wait-state ready/rdata handshake back to the decoder's read mux.

---
 rtl/gpio_port_pkg.sv | 29 ++
 rtl/gpio_sync.sv | 25 ++
 rtl/gpio_port.sv | 129 ++++++++++++
 3 files changed

// File: rtl/gpio_port_pkg.sv
// Shared definitions for the memory-mapped GPIO port: register indices,
// byte offsets within the GPIO window and the byte-lane mask helper.
package gpio_port_pkg;

  typedef enum logic [2:0] {
    REG_DDR   = 3'd0,
    REG_PORT  = 3'd1,
    REG_PIN   = 3'd2,
    REG_PCMSK = 3'd3,
    REG_PCIFR = 3'd4,
    REG_SET   = 3'd5,
    REG_CLR   = 3'd6,
    REG_RSVD  = 3'd7
  } gpio_reg_e;

  localparam logic [31:0] GPIO_DDR_OFF   = 32'h0000_0000;
  localparam logic [31:0] GPIO_PORT_OFF  = 32'h0000_0004;
  localparam logic [31:0] GPIO_PIN_OFF   = 32'h0000_0008;
  localparam logic [31:0] GPIO_PCMSK_OFF = 32'h0000_000C;
  localparam logic [31:0] GPIO_PCIFR_OFF = 32'h0000_0010;
  localparam logic [31:0] GPIO_SET_OFF   = 32'h0000_0014;
  localparam logic [31:0] GPIO_CLR_OFF   = 32'h0000_0018;

  // Expands the four byte strobes into a 32-bit per-bit write mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchroniser for asynchronous inputs; shared by any block that
// needs to bring pad-level signals into the clk domain.
module gpio_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gpio_port.sv
// Memory-mapped GPIO port with DDR/PORT/PIN registers, set/clear/toggle
// writes, pin-change interrupt flags and a one-wait-state bus handshake.
module gpio_port
  import gpio_port_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             gpio_mem_valid,
  input  logic [31:0]      gpio_mem_addr,
  input  logic [31:0]      gpio_mem_wdata,
  input  logic [3:0]       gpio_mem_wstrb,
  output logic [31:0]      gpio_mem_rdata,
  output logic             gpio_mem_ready,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  gpio_reg_e        reg_sel;
  logic             accept;
  logic             wr_en;
  logic             rd_en;
  logic [31:0]      strb_bits;
  logic [31:0]      wr_bits_full;
  logic [31:0]      rd_word;
  logic [WIDTH-1:0] wr_mask;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] ddr;
  logic [WIDTH-1:0] port;
  logic [WIDTH-1:0] pcmsk;
  logic [WIDTH-1:0] pcifr;
  logic [WIDTH-1:0] ddr_next;
  logic [WIDTH-1:0] port_next;
  logic [WIDTH-1:0] pcmsk_next;
  logic [WIDTH-1:0] pcifr_next;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] pin_s;
  logic [WIDTH-1:0] pin_prev;
  logic [WIDTH-1:0] chg;
  logic             unused_bits;

  // The accept edge is the one that raises ready; all side effects happen there.
  assign reg_sel      = gpio_reg_e'(gpio_mem_addr[4:2]);
  assign accept       = gpio_mem_valid & ~gpio_mem_ready;
  assign wr_en        = accept & (|gpio_mem_wstrb);
  assign rd_en        = accept & ~(|gpio_mem_wstrb);
  assign strb_bits    = lane_mask(gpio_mem_wstrb);
  assign wr_bits_full = gpio_mem_wdata & strb_bits;
  assign wr_mask      = strb_bits[WIDTH-1:0];
  assign wr_bits      = wr_bits_full[WIDTH-1:0];

  assign unused_bits = &{1'b0, gpio_mem_addr[31:5], gpio_mem_addr[1:0],
                         wr_bits_full, strb_bits};

  gpio_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (gpio_in),
    .q      (pin_s)
  );

  assign chg = pin_s ^ pin_prev;

  // A flag being set wins over a simultaneous write-one-to-clear of that bit.
  always_comb begin
    ddr_next   = ddr;
    port_next  = port;
    pcmsk_next = pcmsk;
    w1c        = '0;
    if (wr_en) begin
      case (reg_sel)
        REG_DDR:   ddr_next   = (ddr & ~wr_mask) | wr_bits;
        REG_PORT:  port_next  = (port & ~wr_mask) | wr_bits;
        REG_PIN:   port_next  = port ^ wr_bits;
        REG_PCMSK: pcmsk_next = (pcmsk & ~wr_mask) | wr_bits;
        REG_PCIFR: w1c        = wr_bits;
        REG_SET:   port_next  = port | wr_bits;
        REG_CLR:   port_next  = port & ~wr_bits;
        default:   ;
      endcase
    end
    pcifr_next = (pcifr & ~w1c) | (chg & pcmsk);
  end

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      REG_DDR:   rd_word[WIDTH-1:0] = ddr;
      REG_PORT:  rd_word[WIDTH-1:0] = port;
      REG_PIN:   rd_word[WIDTH-1:0] = pin_s;
      REG_PCMSK: rd_word[WIDTH-1:0] = pcmsk;
      REG_PCIFR: rd_word[WIDTH-1:0] = pcifr;
      default:   rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gpio_mem_ready <= 1'b0;
      gpio_mem_rdata <= '0;
      ddr            <= '0;
      port           <= '0;
      pcmsk          <= '0;
      pcifr          <= '0;
      pin_prev       <= '0;
      irq            <= 1'b0;
    end else begin
      gpio_mem_ready <= gpio_mem_valid & ~gpio_mem_ready;
      gpio_mem_rdata <= rd_en ? rd_word : '0;
      ddr            <= ddr_next;
      port           <= port_next;
      pcmsk          <= pcmsk_next;
      pcifr          <= pcifr_next;
      pin_prev       <= pin_s;
      irq            <= |pcifr_next;
    end
  end

  assign gpio_out = port;
  assign gpio_oe  = ddr;

endmodule
